// File: rtl/alu_arbiter.sv
// Round-robin front end for a single shared registered ALU: grants one requester at a time,
// sequences operand load / enable / result capture and returns the result tagged with its id.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_op1,
  input  logic [NUM_REQ*DATA_W-1:0]   req_op2,
  input  logic [NUM_REQ*2-1:0]        req_sel,
  output logic [DATA_W-1:0]           alu_operand1,
  output logic [DATA_W-1:0]           alu_operand2,
  output logic [1:0]                  alu_select,
  output logic                        alu_enable,
  input  logic [DATA_W-1:0]           alu_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        busy
);

  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     last_q, last_d;

  logic [ID_W-1:0]     win_id_c;
  logic                any_valid_c;
  logic                grant_c;
  logic [DATA_W-1:0]   win_op1_c;
  logic [DATA_W-1:0]   win_op2_c;
  logic [SEL_W-1:0]    win_sel_c;

  // First valid requester searching upward from the one after the last grant.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            hit;
    int unsigned     idx;
    pick = '0;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!hit && v[ID_W'(idx)]) begin
        pick = ID_W'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  assign any_valid_c = |req_valid;
  assign win_id_c    = rr_pick(req_valid, last_q);
  // Gated by reset so no accept strobe is seen while the block is held in reset.
  assign grant_c     = (state_q == ST_IDLE) && any_valid_c && reset;

  always_comb begin
    req_ready = '0;
    if (grant_c) begin
      req_ready = NUM_REQ'(1) << win_id_c;
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    win_op1_c = '0;
    win_op2_c = '0;
    win_sel_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_id_c == ID_W'(i)) begin
        win_op1_c = req_op1[i*DATA_W +: DATA_W];
        win_op2_c = req_op2[i*DATA_W +: DATA_W];
        win_sel_c = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sel_d       = sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    last_d      = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          op1_d    = win_op1_c;
          op2_d    = win_op2_c;
          sel_d    = win_sel_c;
          rsp_id_d = win_id_c;
          last_d   = win_id_c;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rsp_data_d  = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer resets to the top index so requester 0 wins the first search.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      sel_q       <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      last_q      <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sel_q       <= sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      last_q      <= last_d;
    end
  end

  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_select   = sel_q;
  assign alu_enable   = (state_q == ST_EXEC);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_id       = rsp_id_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU attached.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 18;
  localparam int unsigned ID_W    = 2;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*DATA_W-1:0]  req_op1;
  logic [NUM_REQ*DATA_W-1:0]  req_op2;
  logic [NUM_REQ*2-1:0]       req_sel;
  logic [DATA_W-1:0]          alu_operand1;
  logic [DATA_W-1:0]          alu_operand2;
  logic [1:0]                 alu_select;
  logic                       alu_enable;
  logic [DATA_W-1:0]          alu_result;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_data;
  logic [ID_W-1:0]            rsp_id;
  logic                       busy;

  logic [DATA_W-1:0] op1_a [NUM_REQ];
  logic [DATA_W-1:0] op2_a [NUM_REQ];
  logic [1:0]        sel_a [NUM_REQ];

  int n_vec;
  int n_err;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_sel      (req_sel),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_select   (alu_select),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op1[i*DATA_W +: DATA_W] = op1_a[i];
      req_op2[i*DATA_W +: DATA_W] = op2_a[i];
      req_sel[i*2 +: 2]           = sel_a[i];
    end
  end

  // Registered, enable-gated ALU: add / AND / NAND / NOR.
  logic [DATA_W-1:0] alu_res_q = '0;
  always_ff @(posedge clk) begin
    if (alu_enable) begin
      case (alu_select)
        2'b00:   alu_res_q <= alu_operand1 + alu_operand2;
        2'b01:   alu_res_q <= alu_operand1 & alu_operand2;
        2'b10:   alu_res_q <= ~(alu_operand1 & alu_operand2);
        default: alu_res_q <= ~(alu_operand1 | alu_operand2);
      endcase
    end
  end
  assign alu_result = alu_res_q;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called #1 after a negedge with the DUT idle; returns #1 after a negedge, idle again.
  task automatic do_op(input int idx, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [1:0] s, input logic [DATA_W-1:0] exp);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << idx;
    op1_a[idx] = a;
    op2_a[idx] = b;
    sel_a[idx] = s;
    req_valid  = oh;
    rsp_ready  = 1'b1;
    #1;
    check_val("op_ready", 32'(req_ready), 32'(oh));
    @(negedge clk); #1;
    req_valid = '0;
    check_val("op_exec_en", 32'(alu_enable), 32'd1);
    check_val("op_exec_a", 32'(alu_operand1), 32'(a));
    check_val("op_exec_b", 32'(alu_operand2), 32'(b));
    check_val("op_exec_sel", 32'(alu_select), 32'(s));
    check_val("op_exec_busy", 32'(busy), 32'd1);
    check_val("op_exec_rdy", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check_val("op_capt_en", 32'(alu_enable), 32'd0);
    check_val("op_capt_vld", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1;
    check_val("op_rsp_vld", 32'(rsp_valid), 32'd1);
    check_val("op_rsp_data", 32'(rsp_data), 32'(exp));
    check_val("op_rsp_id", 32'(rsp_id), 32'(idx));
    @(negedge clk); #1;
    check_val("op_done_vld", 32'(rsp_valid), 32'd0);
    check_val("op_done_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_a"}, 32'(alu_operand1), 32'd0);
    check_val({tag, "_b"}, 32'(alu_operand2), 32'd0);
    check_val({tag, "_sel"}, 32'(alu_select), 32'd0);
    check_val({tag, "_en"}, 32'(alu_enable), 32'd0);
    check_val({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_data"}, 32'(rsp_data), 32'd0);
    check_val({tag, "_id"}, 32'(rsp_id), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_rdy"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int cnt;
    int prev;
    logic [DATA_W-1:0] exp_d;
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op1_a[i] = '0;
      op2_a[i] = '0;
      sel_a[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    reset = 1'b1;
    #1;

    // Basic add, then wrap / NOR / NAND / AND corners on different requesters.
    do_op(0, 18'd3, 18'd5, 2'b00, 18'd8);
    do_op(1, 18'h3FFFF, 18'd1, 2'b00, 18'd0);
    do_op(2, 18'd0, 18'd0, 2'b11, 18'h3FFFF);
    do_op(3, 18'h3FFFF, 18'h3FFFF, 2'b10, 18'd0);
    do_op(1, 18'h0F0F0, 18'h0FF00, 2'b01, 18'h0F000);

    // Mid-run reset while EXEC with everyone requesting; pointer was at 1 so 2 wins first.
    for (int i = 0; i < NUM_REQ; i++) begin
      op1_a[i] = DATA_W'(i * 16 + 1);
      op2_a[i] = DATA_W'(i + 2);
      sel_a[i] = 2'b00;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    check_val("pre_rst_grant", 32'(req_ready), 32'b0100);
    @(negedge clk); #1;
    check_val("pre_rst_en", 32'(alu_enable), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_exec");
    repeat (3) begin
      @(negedge clk); #1;
      check_val("rst_hold_vld", 32'(rsp_valid), 32'd0);
      check_val("rst_hold_rdy", 32'(req_ready), 32'd0);
    end
    reset = 1'b1;
    #1;

    // Continuous requests: rotating grants 0,1,2,3,0,1 every 4 cycles.
    for (int g = 0; g < 6; g++) begin
      if (g > 0) begin
        prev = (g - 1) % NUM_REQ;
        exp_d = op1_a[prev] + op2_a[prev];
        cnt = 0;
        do begin
          @(negedge clk); #1;
          cnt++;
          if (cnt == 3) begin
            check_val("rr_rsp_id", 32'(rsp_id), 32'(prev));
            check_val("rr_rsp_data", 32'(rsp_data), 32'(exp_d));
          end
        end while (req_ready == '0 && cnt < 12);
        check_val("rr_gap", 32'(cnt), 32'd4);
      end
      check_val("rr_grant", 32'(req_ready), 32'(NUM_REQ'(1) << (g % NUM_REQ)));
    end

    // Back-pressure: requester 1 granted now, response held while rsp_ready is low.
    rsp_ready = 1'b0;
    @(negedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_val("bp_vld", 32'(rsp_valid), 32'd1);
    check_val("bp_data", 32'(rsp_data), 32'd20);
    check_val("bp_id", 32'(rsp_id), 32'd1);
    repeat (5) begin
      @(negedge clk); #1;
      check_val("bp_hold_vld", 32'(rsp_valid), 32'd1);
      check_val("bp_hold_data", 32'(rsp_data), 32'd20);
      check_val("bp_hold_id", 32'(rsp_id), 32'd1);
      check_val("bp_hold_busy", 32'(busy), 32'd1);
      check_val("bp_hold_rdy", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check_val("bp_rel_vld", 32'(rsp_valid), 32'd0);
    check_val("bp_rel_busy", 32'(busy), 32'd0);
    check_val("bp_rel_grant", 32'(req_ready), 32'b0100);

    // Reset during EXEC drops the op; afterwards requester 0 beats requester 3.
    @(negedge clk); #1;
    req_valid = '0;
    check_val("rst2_en", 32'(alu_enable), 32'd1);
    reset = 1'b0;
    #1;
    check_val("rst2_vld", 32'(rsp_valid), 32'd0);
    check_val("rst2_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      check_val("rst2_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1001;
    #1;
    check_val("rst2_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
